nios2_debug_ocimem_arbiter: RTL and testbench

Shares the Nios II on-chip debug RAM (OCI memory, single port, one-cycle read latency) between two masters: the JTAG debug path and the CPU's debug-memory Avalon-MM slave. The JTAG path arrives as `jdo` plus the `take_action_ocimem_*` / `take_no_action_ocimem_a` strobes, already in the `clk` domain. The block decodes those strobes into address-load, read and write commands and keeps an auto-incrementing JTAG address. It round-robins the RAM port between the two masters and returns JTAG read data in `MonDReg`.

---
 rtl/nios2_debug_pkg.sv | 27 ++
 rtl/nios2_debug_rr_arb2.sv | 43 ++++
 rtl/nios2_debug_ocimem_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_nios2_debug_ocimem_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_debug_pkg.sv
// nios2_debug_pkg: shared types and jdo field positions
// for the OCI debug-memory arbiter.
package nios2_debug_pkg;

  localparam int JDO_W        = 38;
  localparam int JDO_RD_BIT   = 35;
  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_WDATA_LO = 3;
  localparam int JDO_ADDR_LO  = 17;

  typedef enum logic [1:0] {
    IDLE,
    JRD,
    CRD
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  typedef enum logic {
    GNT_CPU,
    GNT_JTAG
  } gnt_e;

endpackage

// File: rtl/nios2_debug_rr_arb2.sv
// nios2_debug_rr_arb2: two-requester round-robin arbiter;
// a tie goes to the requester not granted last.
module nios2_debug_rr_arb2
  import nios2_debug_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_jtag,
  input  logic i_req_cpu,
  output logic o_gnt_jtag,
  output logic o_gnt_cpu
);

  gnt_e r_last;

  // grant a lone requester, or the one that lost the last tie
  always_comb begin
    o_gnt_jtag = 1'b0;
    o_gnt_cpu  = 1'b0;
    if (i_en) begin
      if (i_req_jtag && i_req_cpu) begin
        o_gnt_jtag = (r_last == GNT_CPU);
        o_gnt_cpu  = (r_last == GNT_JTAG);
      end else begin
        o_gnt_jtag = i_req_jtag;
        o_gnt_cpu  = i_req_cpu;
      end
    end
  end

  // remember who was served most recently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= GNT_CPU;
    end else if (o_gnt_jtag) begin
      r_last <= GNT_JTAG;
    end else if (o_gnt_cpu) begin
      r_last <= GNT_CPU;
    end
  end

endmodule

// File: rtl/nios2_debug_ocimem_arbiter.sv
// nios2_debug_ocimem_arbiter: shares the single-port OCI debug
// RAM between the JTAG debug path and the CPU debug slave.
module nios2_debug_ocimem_arbiter
  import nios2_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_rst_done;
  logic              r_pend_v;
  op_e               r_pend_op;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [31:0]       r_pend_data;
  logic [ADDR_W-1:0] r_jaddr;
  logic [31:0]       r_mon;
  logic              r_ovr;

  logic              w_sel_b;
  logic              w_sel_a;
  logic              w_sel_n;
  logic              w_any;
  logic              w_multi;
  logic              w_drop;
  logic [ADDR_W-1:0] w_jdo_addr;
  logic [31:0]       w_jdo_wdata;
  logic              w_jdo_rd;
  logic              w_acc_v;
  op_e               w_acc_op;
  logic [ADDR_W-1:0] w_acc_addr;
  logic              w_jaddr_ld;
  logic [ADDR_W-1:0] w_jaddr_nxt;
  logic              w_arb_en;
  logic              w_cpu_req;
  logic              w_gnt_j;
  logic              w_gnt_c;
  logic              w_cpu_done;
  logic              w_pend_clr;
  logic              w_unused;

  assign w_jdo_addr  = jdo[JDO_ADDR_LO+ADDR_W-1:JDO_ADDR_LO];
  assign w_jdo_wdata = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
  assign w_jdo_rd    = jdo[JDO_RD_BIT];
  assign w_unused    = ^{jdo[JDO_W-1:JDO_RD_BIT+1],
                         jdo[JDO_WDATA_LO-1:0]};

  // strobe priority: ocimem_b, then ocimem_a, then no_action_a
  assign w_sel_b = take_action_ocimem_b;
  assign w_sel_a = take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_sel_n = take_no_action_ocimem_a
                 & ~take_action_ocimem_a
                 & ~take_action_ocimem_b;
  assign w_any   = take_action_ocimem_b
                 | take_action_ocimem_a
                 | take_no_action_ocimem_a;
  assign w_multi = (take_action_ocimem_b & take_action_ocimem_a)
                 | (take_action_ocimem_b & take_no_action_ocimem_a)
                 | (take_action_ocimem_a & take_no_action_ocimem_a);
  assign w_drop  = (w_any & r_pend_v) | w_multi;

  // decode the winning strobe into a command and address update
  always_comb begin
    w_acc_v     = 1'b0;
    w_acc_op    = OP_RD;
    w_acc_addr  = r_jaddr;
    w_jaddr_ld  = 1'b0;
    w_jaddr_nxt = r_jaddr + 1'b1;
    unique case (1'b1)
      w_sel_b: begin
        w_acc_v    = 1'b1;
        w_acc_op   = OP_WR;
        w_jaddr_ld = 1'b1;
      end
      w_sel_a: begin
        w_acc_v     = w_jdo_rd;
        w_acc_addr  = w_jdo_addr;
        w_jaddr_ld  = 1'b1;
        w_jaddr_nxt = w_jdo_addr;
      end
      w_sel_n: begin
        w_acc_v    = 1'b1;
        w_jaddr_ld = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_cpu_req  = avs_read | avs_write;
  assign w_arb_en   = (r_state == IDLE) & r_rst_done;
  assign w_pend_clr = (r_state == JRD)
                    | (w_gnt_j & (r_pend_op == OP_WR));

  nios2_debug_rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_en       (w_arb_en),
    .i_req_jtag (r_pend_v),
    .i_req_cpu  (w_cpu_req),
    .o_gnt_jtag (w_gnt_j),
    .o_gnt_cpu  (w_gnt_c)
  );

  // accept a JTAG command only into an empty pending slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_v    <= 1'b0;
      r_pend_op   <= OP_RD;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_jaddr     <= '0;
    end else if (!r_pend_v) begin
      if (w_acc_v) begin
        r_pend_v    <= 1'b1;
        r_pend_op   <= w_acc_op;
        r_pend_addr <= w_acc_addr;
        r_pend_data <= w_jdo_wdata;
      end
      if (w_jaddr_ld) begin
        r_jaddr <= w_jaddr_nxt;
      end
    end else if (w_pend_clr) begin
      r_pend_v <= 1'b0;
    end
  end

  // sticky flag for any dropped JTAG strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr <= 1'b0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
    end
  end

  // capture JTAG read data in the cycle after its grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mon <= '0;
    end else if (r_state == JRD) begin
      r_mon <= ram_rdata;
    end
  end

  // hold off grants for one cycle after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // reads leave IDLE for one data cycle; writes stay in IDLE
  always_comb begin
    w_state_nxt = IDLE;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_j && (r_pend_op == OP_RD)) begin
          w_state_nxt = JRD;
        end else if (w_gnt_c && !avs_write) begin
          w_state_nxt = CRD;
        end
      end
      JRD:     w_state_nxt = IDLE;
      CRD:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // drive the RAM port and the CPU response
  always_comb begin
    ram_addr     = '0;
    ram_wren     = 1'b0;
    ram_wdata    = '0;
    avs_readdata = '0;
    w_cpu_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_j) begin
          ram_addr = r_pend_addr;
          if (r_pend_op == OP_WR) begin
            ram_wren  = 1'b1;
            ram_wdata = r_pend_data;
          end
        end else if (w_gnt_c) begin
          ram_addr = avs_address;
          if (avs_write) begin
            ram_wren   = 1'b1;
            ram_wdata  = avs_writedata;
            w_cpu_done = 1'b1;
          end
        end
      end
      CRD: begin
        avs_readdata = ram_rdata;
        w_cpu_done   = 1'b1;
      end
      default: ;
    endcase
  end

  assign avs_waitrequest = w_cpu_req & ~w_cpu_done;
  assign MonDReg         = r_mon;
  assign jtag_busy       = r_pend_v;
  assign jtag_overrun    = r_ovr;

endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// tb_nios2_debug_ocimem_arbiter: vector table, directed
// arbitration/reset sequences and a random transaction model.
module tb_nios2_debug_ocimem_arbiter;

  localparam int K_LD   = 0;
  localparam int K_LDRD = 1;
  localparam int K_RD   = 2;
  localparam int K_WR   = 3;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        jtag_busy;
  logic        jtag_overrun;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic        tb_fill;
  logic [15:0] fill_seed;

  logic [31:0] rdv;
  int          wv;
  logic [7:0]  m_ja;

  typedef struct {
    int          k;
    logic [7:0]  a;
    logic [31:0] d;
    logic [7:0]  ea;
    logic [31:0] em;
  } vec_t;
  vec_t tv [8];

  nios2_debug_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .jtag_busy               (jtag_busy),
    .jtag_overrun            (jtag_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [7:0] i,
                                      input logic [15:0] s);
    if (s == 16'd0 && i == 8'h10) return 32'hDEADBEEF;
    return {s, 8'hA5, i};
  endfunction

  // single-port RAM with one-cycle registered read
  always @(posedge clk) begin
    if (tb_fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i), fill_seed);
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [37:0] jdo_ld(input logic rd,
                                         input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdo_wr(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_mon"}, MonDReg, 32'h0);
    chk({nm, "_busy"}, {31'b0, jtag_busy}, 32'h0);
    chk({nm, "_ovr"}, {31'b0, jtag_overrun}, 32'h0);
    chk({nm, "_wren"}, {31'b0, ram_wren}, 32'h0);
    chk({nm, "_addr"}, {24'b0, ram_addr}, 32'h0);
    chk({nm, "_wdata"}, ram_wdata, 32'h0);
    chk({nm, "_rdata"}, avs_readdata, 32'h0);
  endtask

  // enters and leaves 1 time unit after a rising edge
  task automatic do_reset(input logic [15:0] seed);
    reset_n = 1'b0;
    fill_seed = seed;
    tb_fill = 1'b1;
    #1;
    chk_reset_outs("rst");
    chk("rst_wait", {31'b0, avs_waitrequest}, 32'h0);
    @(posedge clk); #1;
    tb_fill = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic jtag_op(input int k, input logic [7:0] a,
                         input logic [31:0] d, input logic [7:0] ea,
                         input logic [31:0] em);
    jdo = (k == K_WR) ? jdo_wr(d) : jdo_ld(k == K_LDRD, a);
    take_action_ocimem_a    = (k == K_LD) || (k == K_LDRD);
    take_no_action_ocimem_a = (k == K_RD);
    take_action_ocimem_b    = (k == K_WR);
    @(posedge clk); #1;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    @(negedge clk);
    if (k == K_LD) begin
      chk("ld_busy", {31'b0, jtag_busy}, 32'h0);
      chk("ld_wren", {31'b0, ram_wren}, 32'h0);
      @(posedge clk); #1;
    end else begin
      chk("j_gaddr", {24'b0, ram_addr}, {24'b0, ea});
      chk("j_gwren", {31'b0, ram_wren}, {31'b0, k == K_WR});
      chk("j_busy0", {31'b0, jtag_busy}, 32'h1);
      if (k == K_WR) chk("j_wdata", ram_wdata, d);
      @(posedge clk); #1;
      if (k == K_WR) begin
        chk("j_mem", mem[ea], d);
        chk("j_wbusy", {31'b0, jtag_busy}, 32'h0);
      end else begin
        chk("j_busy1", {31'b0, jtag_busy}, 32'h1);
        @(posedge clk); #1;
        chk("j_mon", MonDReg, em);
        chk("j_rbusy", {31'b0, jtag_busy}, 32'h0);
      end
    end
  endtask

  task automatic cpu_op(input bit wr, input logic [7:0] a,
                        input logic [31:0] d,
                        output logic [31:0] rd, output int waits);
    bit done;
    avs_address = a;
    avs_write = wr;
    avs_read = !wr;
    avs_writedata = d;
    waits = 0;
    rd = '0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        rd = avs_readdata;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 20) begin
          n_chk++;
          n_fail++;
          $display("FAIL cpu_timeout: waitrequest stuck at addr %h", a);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    tb_fill = 1'b0;
    fill_seed = '0;

    tv[0] = '{K_LDRD, 8'h10, 32'h0, 8'h10, 32'hDEADBEEF};
    tv[1] = '{K_LD,   8'hFF, 32'h0, 8'h00, 32'h0};
    tv[2] = '{K_WR,   8'h00, 32'h1, 8'hFF, 32'h0};
    tv[3] = '{K_WR,   8'h00, 32'h2, 8'h00, 32'h0};
    tv[4] = '{K_RD,   8'h00, 32'h0, 8'h01, 32'h0000A501};
    tv[5] = '{K_LDRD, 8'hFF, 32'h0, 8'hFF, 32'h1};
    tv[6] = '{K_RD,   8'h00, 32'h0, 8'hFF, 32'h1};
    tv[7] = '{K_RD,   8'h00, 32'h0, 8'h00, 32'h2};

    @(posedge clk); #1;
    avs_write = 1'b1;
    #1;
    chk("rst_req_wait", {31'b0, avs_waitrequest}, 32'h1);
    chk("rst_req_wren", {31'b0, ram_wren}, 32'h0);
    avs_write = 1'b0;
    do_reset(16'd0);

    for (int i = 0; i < 8; i++) begin
      jtag_op(tv[i].k, tv[i].a, tv[i].d, tv[i].ea, tv[i].em);
    end
    chk("wrap_ff", mem[8'hFF], 32'h1);
    chk("wrap_00", mem[8'h00], 32'h2);

    // tie after reset: JTAG first, CPU waits two extra cycles
    do_reset(16'd1);
    jdo = jdo_ld(1'b1, 8'h20);
    take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    fork
      cpu_op(1'b0, 8'h40, 32'h0, rdv, wv);
      begin
        @(negedge clk);
        chk("tie1_jgnt", {24'b0, ram_addr}, 32'h20);
        repeat (2) @(posedge clk);
        #1;
        chk("tie1_mon", MonDReg, pat(8'h20, 16'd1));
      end
    join
    chk("tie1_cwait", wv, 32'd3);
    chk("tie1_crd", rdv, pat(8'h40, 16'd1));

    jtag_op(K_WR, 8'h00, 32'h55, 8'h20, 32'h0);

    // repeat tie after a JTAG grant: CPU first
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b0;
    fork
      cpu_op(1'b0, 8'h41, 32'h0, rdv, wv);
      begin
        @(negedge clk);
        chk("tie2_cgnt", {24'b0, ram_addr}, 32'h41);
        chk("tie2_busy", {31'b0, jtag_busy}, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        chk("tie2_mon", MonDReg, pat(8'h21, 16'd1));
        chk("tie2_idle", {31'b0, jtag_busy}, 32'h0);
      end
    join
    chk("tie2_cwait", wv, 32'd1);
    chk("tie2_crd", rdv, pat(8'h41, 16'd1));

    // second strobe while the first is held behind a CPU read
    chk("ovr_pre", {31'b0, jtag_overrun}, 32'h0);
    avs_read = 1'b1;
    avs_address = 8'h42;
    jdo = jdo_wr(32'h111);
    take_action_ocimem_b = 1'b1;
    @(posedge clk); #1;
    jdo = jdo_wr(32'h222);
    @(negedge clk);
    chk("ovr_cdone", {31'b0, avs_waitrequest}, 32'h0);
    chk("ovr_busy", {31'b0, jtag_busy}, 32'h1);
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    avs_read = 1'b0;
    chk("ovr_set", {31'b0, jtag_overrun}, 32'h1);
    @(negedge clk);
    chk("ovr_gaddr", {24'b0, ram_addr}, 32'h22);
    chk("ovr_gdata", ram_wdata, 32'h111);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("ovr_mem1", mem[8'h22], 32'h111);
    chk("ovr_mem2", mem[8'h23], pat(8'h23, 16'd1));
    jtag_op(K_RD, 8'h00, 32'h0, 8'h23, pat(8'h23, 16'd1));
    chk("ovr_sticky", {31'b0, jtag_overrun}, 32'h1);
    do_reset(16'd1);

    // async reset in the CPU read data cycle
    avs_read = 1'b1;
    avs_address = 8'h50;
    @(negedge clk);
    chk("mid_gnt", {24'b0, ram_addr}, 32'h50);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    chk("mid_wait", {31'b0, avs_waitrequest}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rd0_wren", {31'b0, ram_wren}, 32'h0);
    chk("rd0_addr", {24'b0, ram_addr}, 32'h0);
    chk("rd0_wait", {31'b0, avs_waitrequest}, 32'h1);
    @(posedge clk); #1;
    cpu_op(1'b0, 8'h50, 32'h0, rdv, wv);
    chk("mid_rd", rdv, pat(8'h50, 16'd1));
    chk("mid_lat", wv, 32'd1);

    // simultaneous strobes: write wins, the read is dropped
    jdo = jdo_wr(32'h77);
    take_action_ocimem_b = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    @(negedge clk);
    chk("multi_wren", {31'b0, ram_wren}, 32'h1);
    chk("multi_wdata", ram_wdata, 32'h77);
    chk("multi_ovr", {31'b0, jtag_overrun}, 32'h1);
    @(posedge clk); #1;
    chk("multi_busy", {31'b0, jtag_busy}, 32'h0);

    // random transactions against a transaction-level model
    begin
      logic [15:0] seed;
      logic [7:0]  a;
      logic [31:0] d;
      int          bad;
      seed = 16'($urandom_range(2, 65535));
      do_reset(seed);
      for (int i = 0; i < 256; i++) shadow[i] = pat(8'(i), seed);
      m_ja = 8'h00;
      for (int n = 0; n < 150; n++) begin
        a = 8'($urandom);
        d = $urandom;
        case ($urandom_range(0, 5))
          0: begin
            jtag_op(K_LD, a, 32'h0, 8'h00, 32'h0);
            m_ja = a;
          end
          1: begin
            m_ja = a;
            jtag_op(K_LDRD, a, 32'h0, a, shadow[a]);
          end
          2: begin
            jtag_op(K_RD, 8'h00, 32'h0, m_ja, shadow[m_ja]);
            m_ja = m_ja + 8'd1;
          end
          3: begin
            jtag_op(K_WR, 8'h00, d, m_ja, 32'h0);
            shadow[m_ja] = d;
            m_ja = m_ja + 8'd1;
          end
          4: begin
            cpu_op(1'b0, a, 32'h0, rdv, wv);
            chk("rnd_crd", rdv, shadow[a]);
            chk("rnd_crlat", wv, 32'd1);
          end
          default: begin
            cpu_op(1'b1, a, d, rdv, wv);
            chk("rnd_cwlat", wv, 32'd0);
            shadow[a] = d;
          end
        endcase
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (mem[i] !== shadow[i]) bad++;
      end
      chk("rnd_memimg", bad, 32'd0);
      chk("rnd_noovr", {31'b0, jtag_overrun}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
